// File: rtl/median_pkg.sv
// Shared types and widths for the median filter host sequencer.
package median_pkg;

  localparam int unsigned A_WIDTH    = 6;
  localparam int unsigned D_WIDTH    = 32;
  localparam int unsigned R_WIDTH    = 8;
  localparam int unsigned IN_ADDR_W  = A_WIDTH;
  localparam int unsigned OUT_ADDR_W = A_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_CAP,
    S_RD_HOLD
  } state_e;

endpackage

// File: rtl/median_host_ctrl_if.sv
// Frame input stream, result output stream and both SRAM B-ports.
interface median_host_ctrl_if;
  import median_pkg::*;

  logic [D_WIDTH-1:0]    In_data;
  logic                  In_valid;
  logic                  In_ready;
  logic [R_WIDTH-1:0]    Out_data;
  logic                  Out_valid;
  logic                  Out_ready;
  logic                  Out_last;
  logic [D_WIDTH-1:0]    MA_di32;
  logic [IN_ADDR_W-1:0]  MA_Addr6;
  logic                  MA_enb;
  logic                  MA_web;
  logic [R_WIDTH-1:0]    MO_do8b;
  logic [R_WIDTH-1:0]    MO_di8b;
  logic [OUT_ADDR_W-1:0] MO_Addr5b;
  logic                  MO_enb;
  logic                  MO_web;

  modport master (
    input  In_data, In_valid, Out_ready, MO_do8b,
    output In_ready, Out_data, Out_valid, Out_last,
           MA_di32, MA_Addr6, MA_enb, MA_web,
           MO_di8b, MO_Addr5b, MO_enb, MO_web
  );

  modport slave (
    output In_data, In_valid, Out_ready, MO_do8b,
    input  In_ready, Out_data, Out_valid, Out_last,
           MA_di32, MA_Addr6, MA_enb, MA_web,
           MO_di8b, MO_Addr5b, MO_enb, MO_web
  );

endinterface

// File: rtl/median_rd_skid.sv
// Result byte register: captures the SRAM read data and holds it until accepted.
module median_rd_skid
  import median_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cap,
  input  logic               i_last,
  input  logic [R_WIDTH-1:0] i_rd_data,
  input  logic               i_ready,
  output logic [R_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_last
);

  logic [R_WIDTH-1:0] r_data;
  logic               r_valid;
  logic               r_last;

  // Data stays put after the handshake; only valid/last are withdrawn.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_cap) begin
      r_data  <= i_rd_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/median_host_ctrl.sv
// Host sequencer: loads one frame into the input SRAM, kicks the median core,
// then streams the result bytes out of the output SRAM.
module median_host_ctrl
  import median_pkg::*;
#(
  parameter int unsigned IN_WORDS  = 64,
  parameter int unsigned OUT_BYTES = 32,
  parameter int unsigned TO_W      = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Start,
  output logic Busy,
  output logic Timeout_err,
  output logic Go_t,
  input  logic Done_t,
  median_host_ctrl_if.master bus
);

  localparam logic [TO_W-1:0] TC_LAST = {TO_W{1'b1}} - TO_W'(1);

  state_e                r_state, w_state_nx;
  logic [IN_ADDR_W-1:0]  r_wc, w_wc_nx;
  logic [OUT_ADDR_W-1:0] r_bc, w_bc_nx;
  logic [TO_W-1:0]       r_tc, w_tc_nx;
  logic                  r_to_err, w_to_err_nx;

  logic               w_last;
  logic               w_cap;
  logic               w_out_hs;
  logic [R_WIDTH-1:0] w_out_data;
  logic               w_out_valid;
  logic               w_out_last;

  assign w_last   = (r_bc == OUT_ADDR_W'(OUT_BYTES - 1));
  assign w_cap    = (r_state == S_RD_CAP);
  assign w_out_hs = w_out_valid & bus.Out_ready;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_wc     <= '0;
      r_bc     <= '0;
      r_tc     <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_wc     <= w_wc_nx;
      r_bc     <= w_bc_nx;
      r_tc     <= w_tc_nx;
      r_to_err <= w_to_err_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_wc_nx     = r_wc;
    w_bc_nx     = r_bc;
    w_tc_nx     = r_tc;
    w_to_err_nx = r_to_err;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nx  = S_LOAD;
          w_wc_nx     = '0;
          w_to_err_nx = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.In_valid) begin
          w_wc_nx = r_wc + IN_ADDR_W'(1);
          if (r_wc == IN_ADDR_W'(IN_WORDS - 1)) w_state_nx = S_GO;
        end
      end
      S_GO: begin
        w_state_nx = S_WAIT;
        w_tc_nx    = '0;
      end
      // Done wins over a timeout landing in the same cycle.
      S_WAIT: begin
        if (Done_t) begin
          w_state_nx = S_RD_ISSUE;
          w_bc_nx    = '0;
        end else begin
          w_tc_nx = r_tc + TO_W'(1);
          if (r_tc == TC_LAST) begin
            w_state_nx  = S_IDLE;
            w_to_err_nx = 1'b1;
          end
        end
      end
      S_RD_ISSUE: w_state_nx = S_RD_CAP;
      S_RD_CAP:   w_state_nx = S_RD_HOLD;
      S_RD_HOLD: begin
        if (w_out_hs) begin
          if (w_last) begin
            w_state_nx = S_IDLE;
          end else begin
            w_bc_nx    = r_bc + OUT_ADDR_W'(1);
            w_state_nx = S_RD_ISSUE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  median_rd_skid u_rd_skid (
    .i_clk     (Clk),
    .i_rst_n   (Rst_n),
    .i_cap     (w_cap),
    .i_last    (w_last),
    .i_rd_data (bus.MO_do8b),
    .i_ready   (bus.Out_ready),
    .o_data    (w_out_data),
    .o_valid   (w_out_valid),
    .o_last    (w_out_last)
  );

  // Port controls are decoded from the state register and gated to 0 outside their phase.
  assign Busy        = (r_state != S_IDLE);
  assign Timeout_err = r_to_err;
  assign Go_t        = (r_state == S_GO);

  assign bus.In_ready  = (r_state == S_LOAD);
  assign bus.MA_enb    = (r_state == S_LOAD) & bus.In_valid;
  assign bus.MA_web    = (r_state == S_LOAD) & bus.In_valid;
  assign bus.MA_Addr6  = (r_state == S_LOAD) ? r_wc : '0;
  assign bus.MA_di32   = (r_state == S_LOAD) ? bus.In_data : '0;
  assign bus.MO_enb    = (r_state == S_RD_ISSUE);
  assign bus.MO_Addr5b = (r_state == S_RD_ISSUE) ? r_bc : '0;
  assign bus.MO_di8b   = '0;
  assign bus.MO_web    = 1'b0;
  assign bus.Out_data  = w_out_data;
  assign bus.Out_valid = w_out_valid;
  assign bus.Out_last  = w_out_last;

endmodule

// File: tb/tb_median_host_ctrl.sv
// Randomized scoreboard bench for median_host_ctrl with SRAM and core models.
module tb_median_host_ctrl;
  import median_pkg::*;

  localparam int unsigned TB_TO_W = 7;
  localparam int NW = 64;
  localparam int NB = 32;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic Start = 1'b0;
  logic Done_t = 1'b0;
  logic Busy, Timeout_err, Go_t;

  median_host_ctrl_if bus();

  median_host_ctrl #(.IN_WORDS(NW), .OUT_BYTES(NB), .TO_W(TB_TO_W)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Start       (Start),
    .Busy        (Busy),
    .Timeout_err (Timeout_err),
    .Go_t        (Go_t),
    .Done_t      (Done_t),
    .bus         (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Output SRAM port B: registered read, data one cycle after the enabled edge.
  logic [7:0] mem_out [NB];
  always @(posedge Clk) if (bus.MO_enb) bus.MO_do8b <= mem_out[bus.MO_Addr5b];

  // Median core: Done_t rises done_dly cycles after Go_t (0 = already high, <0 = never).
  int done_dly = -1;
  int done_cnt = -1;
  always @(negedge Clk) begin
    if (Go_t) begin
      if (done_dly == 0) begin
        Done_t = 1'b1;
        done_cnt = -1;
      end else begin
        Done_t = 1'b0;
        done_cnt = done_dly;
      end
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) Done_t = 1'b1;
    end
  end

  // Scoreboard queues filled by stimulus, drained by the monitor.
  wr_t        wr_q[$];
  logic [8:0] out_q[$];

  bit         mon_en = 1'b0;
  int         go_cnt = 0, rd_cnt = 0, out_cnt = 0;
  int         go_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0] prev_d = '0;
  wr_t        mw;
  logic [8:0] me;

  always @(negedge Clk) begin
    if (Rst_n && mon_en) begin
      if (bus.MA_enb) begin
        chk("ma_web", 64'(bus.MA_web), 64'd1);
        chk("ma_enb_needs_valid", 64'(bus.In_valid), 64'd1);
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", 64'(bus.MA_Addr6), 64'hFFFF);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", 64'(bus.MA_Addr6), 64'(mw.a));
          chk("wr_data", 64'(bus.MA_di32), 64'(mw.d));
          if (mw.a == 6'd0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
        end
      end
      if (Go_t) begin
        go_cnt++;
        go_cyc = cyc;
        chk("go_after_last_write", 64'(cyc - last_wr_cyc), 64'd1);
      end
      if (bus.MO_enb) rd_cnt++;
      if (bus.Out_valid) out_cnt++;
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(bus.Out_valid), 64'd1);
        chk("hold_data", 64'(bus.Out_data), 64'(prev_d));
        chk("hold_last", 64'(bus.Out_last), 64'(prev_l));
      end
      if (bus.Out_valid && bus.Out_ready) begin
        if (out_q.size() == 0) begin
          chk("unexpected_out_byte", 64'(bus.Out_data), 64'h1FF);
        end else begin
          me = out_q.pop_front();
          chk("out_data", 64'(bus.Out_data), 64'(me[7:0]));
          chk("out_last", 64'(bus.Out_last), 64'(me[8]));
        end
      end
      prev_v = bus.Out_valid;
      prev_r = bus.Out_ready;
      prev_d = bus.Out_data;
      prev_l = bus.Out_last;
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, 64'({Busy, Timeout_err, bus.In_ready, bus.Out_valid, bus.Out_last, Go_t,
                             bus.MA_enb, bus.MA_web, bus.MO_enb, bus.MO_web,
                             bus.MA_Addr6, bus.MO_Addr5b}), 64'd0);
    chk({name, "_data"}, 64'({bus.MA_di32, bus.Out_data, bus.MO_di8b}), 64'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    bit hs;
    int g;
    hs = 1'b0;
    g = 0;
    bus.In_valid = 1'b1;
    bus.In_data  = w;
    while (!hs && g < 50) begin
      @(negedge Clk);
      hs = bus.In_ready;
      @(posedge Clk); #1;
      g++;
    end
    if (!hs) chk("in_handshake_timeout", 64'(hs), 64'd1);
    bus.In_valid = 1'b0;
  endtask

  task automatic reset_mid_load();
    logic [31:0] w;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      wr_q.push_back({6'(i), w});
      send_word(w);
    end
    Rst_n = 1'b0;
    bus.In_data = 32'hDEADBEEF;
    @(posedge Clk); #1;
    check_zero("reset_mid_load");
    chk("reset_mid_load_wr_q", 64'(wr_q.size()), 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  // vmode: 0 In_valid always 1, 1 alternating, 2 random gaps with Start held high.
  task automatic run_frame(input int vmode, input int dly, input bit stall7,
                           input bit rnd_ready, input bit incr);
    int go0, rd0, out0, stall_cnt, guard, idle_cyc;
    bit to;
    logic [31:0] w;
    to = (dly < 0);
    done_dly = dly;
    for (int i = 0; i < NB; i++) begin
      mem_out[i] = incr ? 8'(8'hA0 + i) : 8'($urandom);
      if (!to) out_q.push_back({(i == NB - 1), mem_out[i]});
    end
    go0 = go_cnt; rd0 = rd_cnt; out0 = out_cnt;

    Start = 1'b1;
    @(posedge Clk); #1;
    chk("busy_after_start", 64'(Busy), 64'd1);
    chk("timeout_err_cleared", 64'(Timeout_err), 64'd0);
    Start = (vmode == 2);

    for (int i = 0; i < NW; i++) begin
      w = incr ? 32'(32'h03020100 + 32'h04040404 * i) : 32'($urandom);
      wr_q.push_back({6'(i), w});
      send_word(w);
      if (vmode == 1 || (vmode == 2 && $urandom_range(0, 1) == 1)) begin
        bus.In_data = $urandom;
        @(posedge Clk); #1;
      end
    end
    Start = 1'b0;

    stall_cnt = 0;
    guard = 0;
    while (Busy && guard < 3000) begin
      if (stall7 && bus.Out_valid && bus.Out_data == 8'hA7 && stall_cnt < 5) begin
        bus.Out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.Out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge Clk); #1;
      guard++;
    end
    idle_cyc = cyc;
    bus.Out_ready = 1'b0;

    chk("frame_completed", 64'(guard < 3000), 64'd1);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("out_q_drained", 64'(out_q.size()), 64'd0);
    chk("go_pulses", 64'(go_cnt - go0), 64'd1);
    chk("mo_reads", 64'(rd_cnt - rd0), to ? 64'd0 : 64'(NB));
    chk("timeout_err", 64'(Timeout_err), 64'(to));
    if (vmode == 0) chk("write_span", 64'(last_wr_cyc - first_wr_cyc), 64'(NW - 1));
    if (stall7) chk("stall_cycles", 64'(stall_cnt), 64'd5);
    if (to) begin
      chk("timeout_out_valid_cycles", 64'(out_cnt - out0), 64'd0);
      chk("timeout_latency", 64'(idle_cyc - go_cyc), 64'(1 << TB_TO_W));
    end
    @(posedge Clk); #1;
    chk("idle_busy", 64'(Busy), 64'd0);
    chk("idle_out_valid", 64'(bus.Out_valid), 64'd0);
    chk("idle_timeout_sticky", 64'(Timeout_err), 64'(to));
  endtask

  initial begin
    bus.In_valid  = 1'b0;
    bus.In_data   = 32'h12345678;
    bus.Out_ready = 1'b0;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset");
    Rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge Clk); #1;

    reset_mid_load();
    run_frame(0, 100, 1'b1, 1'b0, 1'b1);
    run_frame(1, 0, 1'b0, 1'b1, 1'b0);
    run_frame(2, int'($urandom_range(1, 20)), 1'b0, 1'b1, 1'b0);
    run_frame(0, -1, 1'b0, 1'b1, 1'b0);
    run_frame(1, 5, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
